// File: rtl/bus_slave_mux_reg.sv
// Registered read-return multiplexer with fixed-priority slave selection,
// a wait-cycle watchdog and a chip-select conflict flag.
module bus_slave_mux_reg #(
  parameter int SLAVE_NUM = 8,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256,
  localparam int SEL_W    = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SLAVE_NUM-1:0]        sCS_,
  input  logic [SLAVE_NUM*DATA_W-1:0] sRdData,
  input  logic [SLAVE_NUM-1:0]        sRdy_,
  output logic [DATA_W-1:0]           mRdData,
  output logic                        mRdy_,
  output logic                        mErr,
  output logic [SEL_W-1:0]            mSel,
  output logic                        mCsConflict
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state;
  logic [SEL_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;

  logic              active;
  logic [SEL_W-1:0]  win;
  logic              win_rdy;
  logic [DATA_W-1:0] win_data;
  int                ones;
  logic              conflict;
  logic              reselect;
  logic [CNT_W-1:0]  eff_cnt;
  logic              timed_out;

  // Descending scan so the lowest selected index is the last one written.
  always_comb begin
    active   = 1'b0;
    win      = '0;
    win_rdy  = 1'b1;
    win_data = '0;
    ones     = 0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (!sCS_[i]) begin
        active   = 1'b1;
        win      = SEL_W'(i);
        win_rdy  = sRdy_[i];
        win_data = sRdData[i*DATA_W +: DATA_W];
        ones     = ones + 1;
      end
    end
    conflict = (ones > 1);
  end

  // A new winner restarts the access: this cycle is checked as elapsed count 0.
  always_comb begin
    reselect  = (state == WAIT) && (idx != win);
    eff_cnt   = reselect ? '0 : cnt;
    timed_out = (TIMEOUT != 0) && (eff_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      mRdData     <= '0;
      mRdy_       <= 1'b1;
      mErr        <= 1'b0;
      mSel        <= '0;
      mCsConflict <= 1'b0;
    end else begin
      mCsConflict <= conflict;
      mRdy_       <= 1'b1;
      mErr        <= 1'b0;
      mRdData     <= '0;
      case (state)
        HOLD: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          if (!active) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            idx <= win;
            if (!win_rdy) begin
              mRdData <= win_data;
              mRdy_   <= 1'b0;
              mSel    <= win;
              state   <= HOLD;
              cnt     <= '0;
            end else if (timed_out) begin
              mRdy_ <= 1'b0;
              mErr  <= 1'b1;
              mSel  <= win;
              state <= HOLD;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= (TIMEOUT != 0) ? eff_cnt + CNT_W'(1) : '0;
            end
          end
        end
      endcase
    end
  end

endmodule
